// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and segment constants for the scanned 3-digit display
// Segment encodings are {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {ONES = 2'd0, TENS = 2'd1, HUND = 2'd2} slot_t;
    typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} phase_t;
    typedef struct packed {slot_t slot; phase_t phase;} state_t;
    typedef struct packed {bcd_t h; bcd_t t; bcd_t o;} digits_t;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    // Element [d] holds the pattern for digit d.
    localparam logic [9:0][6:0] SEG_DIGITS = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                              7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    function automatic slot_t next_slot(slot_t s);
        return (s == ONES) ? TENS : (s == TENS) ? HUND : ONES;
    endfunction
endpackage

// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: control, digit and display signals of the scanner
// enable/load/h/t/o flow master->slave; seg/an/frame_done flow slave->master.
interface seven_seg_scan_if;
    logic       enable;
    logic       load;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;
    modport master (output enable, load, h, t, o, input seg, an, frame_done);
    modport slave  (input enable, load, h, t, o, output seg, an, frame_done);
endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to active-low segment pattern
// Ports: bcd (4-bit digit in), seg (7-bit {g..a} out); codes 10-15 show a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);
    assign seg = (bcd > 4'd9) ? SEG_DASH : SEG_DIGITS[bcd];
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed 3-digit seven-segment driver with shadow/active digit registers
// Ports: clk, reset_n (async active-low), bus (slave: enable, load, h/t/o in; seg, an, frame_done out).
// Slots scan ONES -> TENS -> HUND, each REFRESH_DIV lit cycles then BLANK_CYCLES dark cycles.
// Define SEVEN_SEG_LZB_EN to blank leading zeros in the HUND and TENS positions.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic           clk,
    input  logic           reset_n,
    seven_seg_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV + BLANK_CYCLES);
    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    digits_t       shadow, active, loaded;
    logic          last, wrap, lit;
    bcd_t          digit;
    logic [6:0]    seg_d;
    logic [2:0]    an_d;
    // A load on the copy cycle bypasses the shadow so the new value is shown at once.
    assign loaded = bus.load ? {bus.h, bus.t, bus.o} : shadow;
    always_comb begin
        last = (cur.phase == SHOW) ? (cnt == CW'(REFRESH_DIV - 1)) : (cnt == CW'(BLANK_CYCLES - 1));
        wrap = bus.enable && last && cur.slot == HUND && cur.phase == BLANK;
        nxt = cur;
        cnt_nxt = cnt + 1'b1;
        if (!bus.enable) begin
            nxt = '{ONES, SHOW};
            cnt_nxt = '0;
        end else if (last) begin
            cnt_nxt = '0;
            nxt.phase = (cur.phase == SHOW) ? BLANK : SHOW;
            nxt.slot = (cur.phase == SHOW) ? cur.slot : next_slot(cur.slot);
        end
    end
    assign digit = (cur.slot == ONES) ? active.o : (cur.slot == TENS) ? active.t : active.h;
`ifdef SEVEN_SEG_LZB_EN
    assign lit = (cur.slot == ONES) || (active.h != 4'd0) || (cur.slot == TENS && active.t != 4'd0);
`else
    assign lit = 1'b1;
`endif
    assign an_d = (!bus.enable || cur.phase == BLANK || !lit) ? 3'b111 :
                  (cur.slot == ONES) ? 3'b110 : (cur.slot == TENS) ? 3'b101 : 3'b011;
    bcd_to_seg u_dec (.bcd(digit), .seg(seg_d));
    // While disabled, active tracks shadow so re-enabling starts on the latest digits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur            <= '{ONES, SHOW};
            cnt            <= '0;
            shadow         <= '0;
            active         <= '0;
            bus.an         <= 3'b111;
            bus.seg        <= SEG_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            cur            <= nxt;
            cnt            <= cnt_nxt;
            if (bus.load) shadow <= {bus.h, bus.t, bus.o};
            if (!bus.enable || wrap) active <= loaded;
            bus.an         <= an_d;
            bus.seg        <= (an_d == 3'b111) ? SEG_OFF : seg_d;
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit per slot (>=2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, all-anodes-off cycles after each digit slot (>=1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  high = scanning; low = display dark.
REQ-006 SHALL have port load  input  1  one-cycle strobe; captures h/t/o into the shadow register.
REQ-007 SHALL have ports h, t, o  input  4 each  BCD hundreds/tens/ones from the binary-to-BCD converter.
REQ-008 SHALL have port seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 SHALL have port an  output  3  anodes {hund,tens,ones}, active-low, registered.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full 3-digit frame.

Function
REQ-011 SHALL hold a shadow digit register (written on load) and an active register (drives display).
REQ-012 SHALL copy shadow to active only at frame boundary (wrap from last blank to D0); if load coincides with boundary, active takes the newly loaded value (bypass).
REQ-013 SHALL scan slots in order ONES -> TENS -> HUND; each slot = SHOW (REFRESH_DIV cycles, one anode low) then BLANK (BLANK_CYCLES cycles, an=3'b111, seg=7'h7F).
REQ-014 SHALL give frame length 3*(REFRESH_DIV+BLANK_CYCLES) cycles; frame_done high on the final BLANK cycle of HUND only.
REQ-015 SHALL decode 0-9 to standard segments (e.g. 0->7'h40, 8->7'h00); codes 10-15 SHALL display dash (7'h3F).
REQ-016 SHALL register outputs: an/seg change one cycle after the state/counter change producing them.
REQ-017 SHALL, with enable low, force an=3'b111, seg=7'h7F, frame_done=0, and hold the scanner at ONES/SHOW count 0; load still updates shadow.
REQ-018 SHALL, on enable rising, copy shadow to active and start a fresh frame at ONES/SHOW count 0.
REQ-019 SHALL keep slot timing identical whether or not a digit is blanked.

Reset
REQ-020 SHALL on reset_n low immediately set an=3'b111, seg=7'h7F, frame_done=0, shadow=active=0, state ONES/SHOW, counter 0.
REQ-021 SHALL, with enable high, drive an=3'b110 on the first rising edge after reset_n deasserts.
REQ-022 SHALL abort any in-progress frame when reset asserts mid-scan; no partial frame_done pulse.

Configuration
REQ-023 SHALL support macro SEVEN_SEG_LZB_EN: when defined, leading-zero blanking -- HUND anode held off if active h==0; TENS also off if h==0 and t==0; ONES always lit.
REQ-024 SHALL, without SEVEN_SEG_LZB_EN, light all three digits always (000 shows "000").

Structure
REQ-025 SHALL place segment encoding constants (digits 0-9, dash, all-off), slot/phase state typedef and digit-index type in package seven_seg_pkg.
REQ-026 SHALL implement the BCD-to-segment lookup as combinational sub-module bcd_to_seg, instantiated once on the muxed digit.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1, frame=15 cycles)
REQ-027 SHALL test: reset release, enable=1, load h/t/o=1/2/3 -> first frame shows 0/0/0, next frame an sequence 110(x4),111,101(x4),111,011(x4),111 with seg 3->7'h30, 2->7'h24, 1->7'h79.
REQ-028 SHALL test: frame_done -> single pulse every 15 cycles, coincident with final HUND blank cycle.
REQ-029 SHALL test: load 9/9/9 mid-frame then load 4/5/6 on boundary cycle -> next frame displays 4/5/6; 9/9/9 never shown.
REQ-030 SHALL test: load h=0,t=0,o=7 with SEVEN_SEG_LZB_EN -> only an[0] ever low (seg 7'h78); without macro -> all three lit, HUND/TENS seg 7'h40.
REQ-031 SHALL test: load t=4'hC -> TENS slot seg=7'h3F.
REQ-032 SHALL test: enable low mid-TENS -> next cycle an=111, seg=7'h7F; re-enable -> an=110 one cycle later, frame restarts; reset_n low mid-frame -> outputs dark asynchronously.
